// File: rtl/switch_scheduler_pkg.sv
// Shared types and helpers for the inter-core vector switch scheduler.
// Round-robin scan helper is reused by every per-receiver arbiter.
package switch_pkg;

  localparam int TIMEOUT_DEF = 256;
  localparam int MAX_CORES   = 32;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // First set bit at or after ptr, wrapping; -1 if none.
  function automatic int rr_first(
    input logic [MAX_CORES-1:0] req,
    input int                   ptr,
    input int                   n
  );
    int s;
    rr_first = -1;
    for (int k = MAX_CORES - 1; k >= 0; k--) begin
      if (k < n) begin
        s = ptr + k;
        if (s >= n) s = s - n;
        if (req[s[4:0]]) rr_first = s;
      end
    end
  endfunction

endpackage

// File: rtl/switch_scheduler_if.sv
// Request/grant bundle between VecCore instances and the scheduler.
// master = cores (drive requests), slave = scheduler (drive grants).
interface switch_scheduler_if
  import switch_pkg::*;
#(
  parameter int CORE_SIZE = 2
);
  localparam int AW = idx_w(CORE_SIZE);

  logic [CORE_SIZE-1:0]         send_ready;
  logic [CORE_SIZE-1:0][AW-1:0] send_core_idx;
  logic [CORE_SIZE-1:0]         recv_request;
  logic [CORE_SIZE-1:0][AW-1:0] recv_core_idx;
  logic [CORE_SIZE-1:0]         recv_any;
  logic [CORE_SIZE-1:0]         send_ok;
  logic [CORE_SIZE-1:0]         recv_ready;
  logic [CORE_SIZE-1:0][AW-1:0] recv_src_idx;
  logic [CORE_SIZE-1:0]         recv_timeout;
  logic                         bad_idx_err;

  modport master (
    output send_ready, send_core_idx,
    output recv_request, recv_core_idx, recv_any,
    input  send_ok, recv_ready, recv_src_idx,
    input  recv_timeout, bad_idx_err
  );

  modport slave (
    input  send_ready, send_core_idx,
    input  recv_request, recv_core_idx, recv_any,
    output send_ok, recv_ready, recv_src_idx,
    output recv_timeout, bad_idx_err
  );

endinterface

// File: rtl/switch_scheduler_rr_arbiter.sv
// Round-robin arbiter: request vector plus pointer to one-hot grant,
// encoded index and valid.
module rr_arbiter
  import switch_pkg::*;
#(
  parameter int N  = 2,
  parameter int AW = 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [AW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [AW-1:0] idx_o,
  output logic          vld_o
);

  logic [MAX_CORES-1:0] req_w;
  int                   win;

  always_comb begin
    req_w         = '0;
    req_w[N-1:0]  = req_i;
    win           = rr_first(req_w, int'(ptr_i), N);
    vld_o         = (win >= 0);
    idx_o         = vld_o ? AW'(win) : '0;
    gnt_o         = '0;
    for (int i = 0; i < N; i++) begin
      gnt_o[i] = vld_o && (win == i);
    end
  end

endmodule

// File: rtl/switch_scheduler.sv
// Control plane of the inter-core vector switch: matches senders to
// receivers, one registered grant per receiver per cycle.
module switch_scheduler
  import switch_pkg::*;
#(
  parameter int CORE_SIZE = 2,
  parameter int TIMEOUT   = TIMEOUT_DEF
) (
  input  logic               clock,
  input  logic               reset,
  switch_scheduler_if.slave  bus
);

  localparam int AW = idx_w(CORE_SIZE);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [CORE_SIZE-1:0][CORE_SIZE-1:0] cand;
  logic [CORE_SIZE-1:0][CORE_SIZE-1:0] gnt;
  logic [CORE_SIZE-1:0]                gvld;
  logic [CORE_SIZE-1:0][AW-1:0]        gidx;

  logic [CORE_SIZE-1:0]         send_ok_q, send_ok_d;
  logic [CORE_SIZE-1:0]         recv_ready_q, recv_ready_d;
  logic [CORE_SIZE-1:0]         timeout_q, timeout_d;
  logic [CORE_SIZE-1:0][AW-1:0] src_q, src_d;
  logic [CORE_SIZE-1:0][AW-1:0] ptr_q, ptr_d;
  logic [CORE_SIZE-1:0][CW-1:0] cnt_q, cnt_d;
  logic                         err_q, err_d;

  // Pulse-cycle exclusion: a side that just got a pulse sits out one edge.
  always_comb begin
    for (int r = 0; r < CORE_SIZE; r++) begin
      for (int s = 0; s < CORE_SIZE; s++) begin
        cand[r][s] = bus.send_ready[s]
                  && (bus.send_core_idx[s] == AW'(r))
                  && bus.recv_request[r]
                  && (bus.recv_any[r]
                      || (bus.recv_core_idx[r] == AW'(s)))
                  && !send_ok_q[s]
                  && !recv_ready_q[r];
      end
    end
  end

  for (genvar r = 0; r < CORE_SIZE; r++) begin : g_arb
    rr_arbiter #(
      .N  (CORE_SIZE),
      .AW (AW)
    ) u_arb (
      .req_i (cand[r]),
      .ptr_i (ptr_q[r]),
      .gnt_o (gnt[r]),
      .idx_o (gidx[r]),
      .vld_o (gvld[r])
    );
  end

  always_comb begin
    send_ok_d    = '0;
    recv_ready_d = '0;
    timeout_d    = '0;
    src_d        = src_q;
    ptr_d        = ptr_q;
    cnt_d        = '0;
    err_d        = err_q;
    for (int r = 0; r < CORE_SIZE; r++) begin
      send_ok_d       = send_ok_d | gnt[r];
      recv_ready_d[r] = gvld[r];
      if (gvld[r]) begin
        src_d[r] = gidx[r];
        ptr_d[r] = (gidx[r] == AW'(CORE_SIZE - 1))
                 ? '0 : gidx[r] + AW'(1);
      end
      // Grant wins over an expiring wait on the same edge.
      if ((TIMEOUT > 0) && bus.recv_request[r] && !gvld[r]) begin
        if (int'(cnt_q[r]) + 1 >= TIMEOUT) begin
          timeout_d[r] = 1'b1;
        end else begin
          cnt_d[r] = cnt_q[r] + CW'(1);
        end
      end
    end
    for (int s = 0; s < CORE_SIZE; s++) begin
      if (bus.send_ready[s]
          && (int'(bus.send_core_idx[s]) >= CORE_SIZE)) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      send_ok_q    <= '0;
      recv_ready_q <= '0;
      timeout_q    <= '0;
      src_q        <= '0;
      ptr_q        <= '0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
    end else begin
      send_ok_q    <= send_ok_d;
      recv_ready_q <= recv_ready_d;
      timeout_q    <= timeout_d;
      src_q        <= src_d;
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
    end
  end

  assign bus.send_ok      = send_ok_q;
  assign bus.recv_ready   = recv_ready_q;
  assign bus.recv_src_idx = src_q;
  assign bus.recv_timeout = timeout_q;
  assign bus.bad_idx_err  = err_q;

endmodule

// File: tb/tb_switch_scheduler.sv
// Scoreboard bench: directed scenarios plus random traffic against a
// behavioural matcher model; a separate monitor checks every cycle.
module tb_switch_scheduler;
  import switch_pkg::*;

  localparam int N  = 4;
  localparam int TO = 8;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic rst3_n = 1'b0;

  always #5 clk = ~clk;

  switch_scheduler_if #(.CORE_SIZE(4)) bus ();
  switch_scheduler_if #(.CORE_SIZE(3)) bus3 ();

  switch_scheduler #(.CORE_SIZE(4), .TIMEOUT(TO)) u_dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus.slave)
  );

  switch_scheduler #(.CORE_SIZE(3), .TIMEOUT(TO)) u_dut3 (
    .clock (clk),
    .reset (rst3_n),
    .bus   (bus3.slave)
  );

  typedef struct packed {
    logic [3:0]      ok;
    logic [3:0]      rr;
    logic [3:0]      to;
    logic [3:0][1:0] src;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_chk  = 0;
  int   n_fail = 0;

  int m_ptr[N];
  int m_cnt[N];
  int m_src[N];
  bit m_ok[N];
  bit m_rr[N];

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: each requesting receiver scans senders from its pointer
  // and takes the first eligible one; waits count whole unmatched edges.
  task automatic model_step();
    exp_t e;
    bit   nok[N];
    bit   nrr[N];
    int   g;
    int   s;
    e = '0;
    for (int i = 0; i < N; i++) begin
      nok[i] = 1'b0;
      nrr[i] = 1'b0;
    end
    for (int r = 0; r < N; r++) begin
      g = -1;
      if (bus.recv_request[r] && !m_rr[r]) begin
        for (int k = 0; k < N; k++) begin
          s = (m_ptr[r] + k) % N;
          if (g < 0 && bus.send_ready[s] && !m_ok[s]
              && int'(bus.send_core_idx[s]) == r
              && (bus.recv_any[r] || int'(bus.recv_core_idx[r]) == s))
            g = s;
        end
      end
      if (g >= 0) begin
        nok[g]   = 1'b1;
        nrr[r]   = 1'b1;
        m_src[r] = g;
        m_ptr[r] = (g + 1) % N;
      end
      if (g >= 0 || !bus.recv_request[r]) begin
        m_cnt[r] = 0;
      end else begin
        m_cnt[r]++;
        if (m_cnt[r] == TO) begin
          m_cnt[r] = 0;
          e.to[r]  = 1'b1;
        end
      end
      e.src[r] = 2'(m_src[r]);
    end
    for (int i = 0; i < N; i++) begin
      m_ok[i]  = nok[i];
      m_rr[i]  = nrr[i];
      e.ok[i]  = nok[i];
      e.rr[i]  = nrr[i];
    end
    q.push_back(e);
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      check("send_ok", 32'(bus.send_ok), 32'(mon_e.ok));
      check("recv_ready", 32'(bus.recv_ready), 32'(mon_e.rr));
      check("recv_timeout", 32'(bus.recv_timeout), 32'(mon_e.to));
      check("recv_src_idx", 32'(bus.recv_src_idx), 32'(mon_e.src));
      check("bad_idx_err", 32'(bus.bad_idx_err), 32'd0);
    end
  end

  task automatic clr();
    bus.send_ready    = '0;
    bus.send_core_idx = '0;
    bus.recv_request  = '0;
    bus.recv_core_idx = '0;
    bus.recv_any      = '0;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    @(negedge clk);
    clr();
    tick();
  endtask

  initial begin
    int ord[3];
    ord = '{0, 1, 3};
    for (int i = 0; i < N; i++) begin
      m_ptr[i] = 0;
      m_cnt[i] = 0;
      m_src[i] = 0;
      m_ok[i]  = 1'b0;
      m_rr[i]  = 1'b0;
    end
    clr();
    bus3.send_ready    = '0;
    bus3.send_core_idx = '0;
    bus3.recv_request  = '0;
    bus3.recv_core_idx = '0;
    bus3.recv_any      = '0;
    repeat (2) @(negedge clk);
    check("rst_send_ok", 32'(bus.send_ok), 32'd0);
    check("rst_recv_ready", 32'(bus.recv_ready), 32'd0);
    check("rst_src", 32'(bus.recv_src_idx), 32'd0);
    check("rst_timeout", 32'(bus.recv_timeout), 32'd0);
    rst_n  = 1'b1;
    rst3_n = 1'b1;

    // Round-robin among s0,s1,s3 into r2.
    bus.send_ready       = 4'b1011;
    bus.send_core_idx[0] = 2'd2;
    bus.send_core_idx[1] = 2'd2;
    bus.send_core_idx[3] = 2'd2;
    bus.recv_request[2]  = 1'b1;
    bus.recv_any[2]      = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("rr_ready2", 32'(bus.recv_ready[2]), 32'(k % 2 == 0));
      if (k % 2 == 0)
        check("rr_src2", 32'(bus.recv_src_idx[2]), 32'(ord[k / 2]));
    end
    idle();

    // Pair match s1 -> r2 with a fixed source.
    @(negedge clk);
    bus.send_ready[1]    = 1'b1;
    bus.send_core_idx[1] = 2'd2;
    bus.recv_request[2]  = 1'b1;
    bus.recv_core_idx[2] = 2'd1;
    tick();
    check("pair_ok", 32'(bus.send_ok), 32'h2);
    check("pair_rr", 32'(bus.recv_ready), 32'h4);
    tick();
    check("pair_ok_drop", 32'(bus.send_ok), 32'h0);
    check("pair_rr_drop", 32'(bus.recv_ready), 32'h0);
    idle();

    // Source filter: r1 only accepts s3.
    @(negedge clk);
    bus.send_ready       = 4'b1001;
    bus.send_core_idx[0] = 2'd1;
    bus.send_core_idx[3] = 2'd1;
    bus.recv_request[1]  = 1'b1;
    bus.recv_core_idx[1] = 2'd3;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("filter_s0", 32'(bus.send_ok[0]), 32'd0);
      if (k == 0) check("filter_s3", 32'(bus.send_ok[3]), 32'd1);
    end
    idle();

    // Four parallel transfers, two of them self-sends.
    @(negedge clk);
    bus.send_ready    = 4'hF;
    bus.send_core_idx = {2'd3, 2'd2, 2'd0, 2'd1};
    bus.recv_request  = 4'hF;
    bus.recv_any      = 4'hF;
    tick();
    check("par_ok", 32'(bus.send_ok), 32'hF);
    check("par_rr", 32'(bus.recv_ready), 32'hF);
    idle();

    // Timeout: r0 waits on idle s2, then s2 shows up.
    for (int k = 0; k < 17; k++) begin
      @(negedge clk);
      bus.recv_request[0]  = 1'b1;
      bus.recv_core_idx[0] = 2'd2;
      if (k == 16) begin
        bus.send_ready[2]    = 1'b1;
        bus.send_core_idx[2] = 2'd0;
      end
      tick();
      check("to_pulse", 32'(bus.recv_timeout[0]), 32'(k == 7 || k == 15));
      if (k == 16) check("to_grant", 32'(bus.recv_ready[0]), 32'd1);
    end
    idle();

    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      bus.send_ready    = 4'($urandom);
      bus.send_core_idx = 8'($urandom);
      bus.recv_request  = 4'($urandom | $urandom);
      bus.recv_core_idx = 8'($urandom);
      bus.recv_any      = 4'($urandom & $urandom);
      tick();
    end
    idle();
    @(posedge clk);
    #3;
    check("queue_drain", 32'(q.size()), 32'd0);

    // Three-core instance: bad destination, then reset mid-pulse.
    @(negedge clk);
    bus3.send_ready       = 3'b001;
    bus3.send_core_idx[0] = 2'd3;
    @(posedge clk);
    #2;
    check("err_set", 32'(bus3.bad_idx_err), 32'd1);
    check("err_no_grant", 32'(bus3.send_ok), 32'd0);
    @(negedge clk);
    bus3.send_ready       = 3'b010;
    bus3.send_core_idx[1] = 2'd2;
    bus3.recv_request[2]  = 1'b1;
    bus3.recv_any[2]      = 1'b1;
    @(posedge clk);
    #2;
    check("c3_rr", 32'(bus3.recv_ready), 32'h4);
    check("c3_err_sticky", 32'(bus3.bad_idx_err), 32'd1);
    #1 rst3_n = 1'b0;
    #1;
    check("rst_mid_rr", 32'(bus3.recv_ready), 32'd0);
    check("rst_mid_ok", 32'(bus3.send_ok), 32'd0);
    check("rst_mid_err", 32'(bus3.bad_idx_err), 32'd0);
    @(negedge clk);
    bus3.send_ready   = '0;
    bus3.recv_request = '0;
    rst3_n = 1'b1;
    @(posedge clk);
    #2;
    check("no_replay", 32'(bus3.recv_ready), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
